mux_scan_seq: RTL

- Parametrised successor to the team's 8:1 single-bit select mux: NCH channels of W bits each, with a registered output stage.
- Two modes:
  - Manual: an external sel picks the channel.
  - Scan: an internal sequencer round-robins over the enabled channels, with a programmable dwell between samples.
- The output is a one-entry valid/ready stage, so downstream consumers can apply backpressure without losing samples.
- Sits between multi-channel sources (sensor/ADC lanes, status buses) and a single shared consumer.

---
 rtl/mux_scan_seq.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mux_scan_seq.sv
// NCH-channel sample mux with manual select or dwell-paced round-robin scan,
// feeding a one-entry valid/ready output register.
module mux_scan_seq #(
  parameter int NCH    = 8,
  parameter int W      = 8,
  parameter int SELW   = $clog2(NCH),
  parameter int DWELLW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*W-1:0]  in_data,
  input  logic [NCH-1:0]    ch_en,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  input  logic [DWELLW-1:0] dwell,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_ch,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD
  } state_e;

  localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);

  state_e            state_q, state_d;
  logic [SELW-1:0]   ptr_q, ptr_d;
  logic [DWELLW-1:0] cnt_q, cnt_d;
  logic [W-1:0]      data_q;
  logic [SELW-1:0]   ch_q;
  logic              valid_q;

  logic [W-1:0]      chan [NCH];
  logic              slot_free;
  logic              any_en;
  logic              sel_ok;
  logic              man_cap;
  logic              cap;
  logic [SELW-1:0]   cap_ch;
  logic [SELW-1:0]   low_en;
  logic [SELW-1:0]   nxt_en;
  logic              nxt_found;

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      chan[k] = in_data[k*W +: W];
    end
  end

  assign slot_free = !valid_q || out_ready;
  assign any_en    = |ch_en;
  assign sel_ok    = {1'b0, sel} < NCH_W;
  assign man_cap   = sel_ok && ch_en[sel];

  always_comb begin
    low_en = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ch_en[i]) low_en = SELW'(i);
    end
  end

  // Next enabled index after ptr, wrapping; ptr itself if it is the only one.
  always_comb begin
    nxt_en    = ptr_q;
    nxt_found = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      if (!nxt_found && ch_en[(int'(ptr_q) + i) % NCH]) begin
        nxt_en    = SELW'((int'(ptr_q) + i) % NCH);
        nxt_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    cap_ch  = ptr_q;
    if (!mode) begin
      state_d = S_IDLE;
      cap     = man_cap && slot_free;
      cap_ch  = sel;
    end else if (!any_en) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          ptr_d   = low_en;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          // >= so a dwell lowered below cnt counts as expiry
          if (cnt_q < dwell) begin
            cnt_d = cnt_q + DWELLW'(1);
          end else if (!ch_en[ptr_q]) begin
            ptr_d = nxt_en;
            cnt_d = '0;
          end else if (slot_free) begin
            cap   = 1'b1;
            ptr_d = nxt_en;
            cnt_d = '0;
          end else begin
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!ch_en[ptr_q]) begin
            ptr_d   = nxt_en;
            cnt_d   = '0;
            state_d = S_WAIT;
          end else if (slot_free) begin
            cap     = 1'b1;
            ptr_d   = nxt_en;
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      if (cap) begin
        data_q  <= chan[cap_ch];
        ch_q    <= cap_ch;
        valid_q <= 1'b1;
      end else if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_valid = valid_q;

endmodule
